// File: rtl/param_load_ctrl.sv
// Parameter loader: streams count words from a synchronous-read parameter memory
// into consecutive mux select codes starting at FIRST_SEL.
module param_load_ctrl #(
  parameter int unsigned FIRST_SEL = 25,
  parameter int unsigned MAX_LINES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [6:0]         base_addr,
  input  logic [4:0]         count,
  input  logic signed [31:0] mem_rdata,
  output logic [6:0]         mem_raddr,
  output logic               mem_ren,
  output logic               mux_en,
  output logic [6:0]         mux_addr,
  output logic signed [31:0] mux_din,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_ISSUE,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [6:0] FIRST_SEL_C = 7'(FIRST_SEL);
  localparam logic [4:0] MAX_CNT_C   = 5'(MAX_LINES);

  state_e     state_q, state_d;
  logic [6:0] base_q, base_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] idx_q, idx_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    mux_en    = 1'b1;
    mem_ren   = 1'b0;
    mux_addr  = '0;
    mem_raddr = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0 && count <= MAX_CNT_C) begin
            base_d  = base_addr;
            cnt_d   = count;
            idx_d   = '0;
            state_d = S_PRIME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Select 0 during PRIME/FLUSH steers the stale/edge-pair write into the mux default sink.
      S_PRIME: begin
        mux_en  = 1'b0;
        busy    = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mux_en    = 1'b0;
        busy      = 1'b1;
        mem_ren   = 1'b1;
        mux_addr  = FIRST_SEL_C + {2'b00, idx_q};
        mem_raddr = base_q + {2'b00, idx_q};
        if (idx_q == cnt_q - 5'd1) begin
          state_d = S_FLUSH;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_FLUSH: begin
        mux_en  = 1'b0;
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mux_din = mem_rdata;
  assign err     = err_q;

endmodule
